// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter with one registered write stage
// and read-operand bypass for an 8-entry register file.
module rf_wb_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [2:0]       req0_reg,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_reg,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             stall,
    input  logic [2:0]       rd1sel,
    input  logic [2:0]       rd2sel,
    input  logic [WIDTH-1:0] rf1data,
    input  logic [WIDTH-1:0] rf2data,
    output logic [WIDTH-1:0] op1data,
    output logic [WIDTH-1:0] op2data,
    output logic [2:0]       writeregsel,
    output logic [WIDTH-1:0] writedata,
    output logic             write,
    output logic             err
);
    logic             stg_valid_q, stg_valid_d;
    logic [2:0]       stg_reg_q, stg_reg_d;
    logic [WIDTH-1:0] stg_data_q, stg_data_d;
    logic             prio_q, prio_d;
    logic             err_q, err_d;
    logic             gnt0, gnt1;

    always_comb begin
        gnt0        = ~stall & req0_valid & (~req1_valid | ~prio_q);
        gnt1        = ~stall & req1_valid & (~req0_valid | prio_q);
        prio_d      = gnt0 ? 1'b1 : gnt1 ? 1'b0 : prio_q;
        stg_valid_d = stall ? stg_valid_q : (gnt0 | gnt1);
        stg_reg_d   = gnt0 ? req0_reg  : gnt1 ? req1_reg  : stg_reg_q;
        stg_data_d  = gnt0 ? req0_data : gnt1 ? req1_data : stg_data_q;
        err_d       = req0_valid & req1_valid & (req0_reg == req1_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_reg_q   <= '0;
            stg_data_q  <= '0;
            prio_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_reg_q   <= stg_reg_d;
            stg_data_q  <= stg_data_d;
            prio_q      <= prio_d;
            err_q       <= err_d;
        end
    end

    // The register file does not write through, so the staged entry is the newest value.
    assign op1data     = (stg_valid_q && stg_reg_q == rd1sel) ? stg_data_q : rf1data;
    assign op2data     = (stg_valid_q && stg_reg_q == rd2sel) ? stg_data_q : rf2data;
    assign req0_ready  = gnt0 & ~rst;
    assign req1_ready  = gnt1 & ~rst;
    assign write       = stg_valid_q & ~stall;
    assign writeregsel = stg_reg_q;
    assign writedata   = stg_data_q;
    assign err         = err_q;
endmodule
